usrt_tx: RTL and testbench

//  Transmit stage of the USRT, directly downstream of busint; consumes its o_Tx_En strobe.
//  - One-deep holding register plus shift register.
//  - Serialises frames on o_Txd, with a companion synchronous bit clock on o_Sclk.
//  - Reports busy, frame-done and overrun status back toward the bus side.

---
 rtl/usrt_tx.sv | 205 ++++++++++++++++++++
 tb/tb_usrt_tx.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_tx.sv
// usrt_tx: USRT transmitter, holding register + shifter, bit clock on o_Sclk.
// Optional parity bit enabled by defining USRT_TX_PARITY_EN.
module usrt_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              i_Pclk,
  input  logic              i_Presetn,
  input  logic              i_Tx_En,
  input  logic [DATA_W-1:0] i_Tx_Data,
  output logic              o_Txd,
  output logic              o_Sclk,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef USRT_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [BW-1:0]     bit_idx, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] hold, hold_n;
  logic              hold_valid, hold_valid_n;
  logic              txd_q, txd_n;
  logic              busy_q, busy_n;
  logic              ovr_q, ovr_n;
  logic              en_q, en_qq;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              bit_end;
  logic              load;
`ifdef USRT_TX_PARITY_EN
  logic              par, par_n;
`endif

  // Input register: the edge is detected one cycle after sampling.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      en_q   <= 1'b0;
      en_qq  <= 1'b0;
      data_q <= '0;
    end else begin
      en_q   <= i_Tx_En;
      en_qq  <= en_q;
      data_q <= i_Tx_Data;
    end
  end

  assign accept  = en_q & ~en_qq;
  assign bit_end = (cnt == CNT_LAST);

  // State and datapath registers.
  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef USRT_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      txd_q      <= txd_n;
      busy_q     <= busy_n;
      ovr_q      <= ovr_n;
`ifdef USRT_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  // Next-state, bit sequencing and holding-register control.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_n        = bit_idx;
    shreg_n      = shreg;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    txd_n        = txd_q;
    ovr_n        = 1'b0;
    load         = 1'b0;
`ifdef USRT_TX_PARITY_EN
    par_n        = par;
`endif

    if (state != S_IDLE) begin
      cnt_n = bit_end ? '0 : cnt + 1'b1;
    end

    unique case (state)
      S_IDLE: load = hold_valid;
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
          txd_n   = shreg[0];
          shreg_n = shreg >> 1;
`ifdef USRT_TX_PARITY_EN
          par_n   = par ^ shreg[0];
`endif
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == BIT_LAST) begin
`ifdef USRT_TX_PARITY_EN
            state_n = S_PARITY;
            txd_n   = par;
`else
            state_n = S_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n   = bit_idx + 1'b1;
            txd_n   = shreg[0];
            shreg_n = shreg >> 1;
`ifdef USRT_TX_PARITY_EN
            par_n   = par ^ shreg[0];
`endif
          end
        end
      end
`ifdef USRT_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (hold_valid) load = 1'b1;
          else state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        txd_n   = 1'b1;
      end
    endcase

    // Hold moves into the shifter; the line drops for the start bit.
    if (load) begin
      state_n      = S_START;
      cnt_n        = '0;
      shreg_n      = hold;
      hold_valid_n = 1'b0;
      txd_n        = 1'b0;
`ifdef USRT_TX_PARITY_EN
      par_n        = PARITY_ODD;
`endif
    end

    // A new write fits if hold is empty or is emptying this cycle.
    if (accept) begin
      if (!hold_valid || load) begin
        hold_n       = data_q;
        hold_valid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end

    busy_n = (state_n != S_IDLE) | hold_valid_n;
  end

  assign o_Txd     = txd_q;
  assign o_Sclk    = (state == S_IDLE) | (cnt >= CNT_HALF);
  assign o_Busy    = busy_q;
  assign o_Done    = (state == S_STOP) & bit_end;
  assign o_Overrun = ovr_q;

endmodule

// File: tb/tb_usrt_tx.sv
// tb_usrt_tx: directed checks of usrt_tx framing, timing and overrun.
// Frames are captured on the rising edge of o_Sclk.
module tb_usrt_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef USRT_TX_PARITY_EN
  localparam int FB  = DW + 3;
`else
  localparam int FB  = DW + 2;
`endif
  localparam int FCLK = FB * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] data = '0;
  logic          txd, sclk, busy, done, ovr;

  int total = 0;
  int bad   = 0;

  logic rxq[$];
  int   done_cnt = 0;
  int   ovr_cnt  = 0;

  usrt_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(DW),
    .PARITY_ODD(1'b0)
  ) dut (
    .i_Pclk(clk),
    .i_Presetn(rst_n),
    .i_Tx_En(en),
    .i_Tx_Data(data),
    .o_Txd(txd),
    .o_Sclk(sclk),
    .o_Busy(busy),
    .o_Done(done),
    .o_Overrun(ovr)
  );

  always #5 clk = ~clk;

  // Receiver model: sample the line on each rising bit clock.
  always @(posedge sclk) begin
    if (rst_n) rxq.push_back(txd);
  end

  // Pulse counters for done / overrun.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ovr) ovr_cnt++;
  end

  function automatic logic [FB-1:0] frame_of(input logic [DW-1:0] d);
    logic [FB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DW:1] = d;
`ifdef USRT_TX_PARITY_EN
    f[DW+1] = ^d;
`endif
    return f;
  endfunction

  task automatic pack_rx(output logic [2*FB-1:0] v, output int n);
    v = '0;
    n = rxq.size();
    for (int i = 0; i < n && i < 2*FB; i++) v[i] = rxq[i];
  endtask

  task automatic clear_mon();
    rxq.delete();
    done_cnt = 0;
    ovr_cnt  = 0;
  endtask

  task automatic bus_write(input logic [DW-1:0] d, input int hold_cyc);
    data = d;
    en   = 1'b1;
    repeat (hold_cyc) @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_timeout: busy=%b required 0", tag, busy);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (txd !== 1'b1) begin
      bad++; $display("FAIL reset_txd: got %b want 1", txd);
    end
    total++;
    if (sclk !== 1'b1) begin
      bad++; $display("FAIL reset_sclk: got %b want 1", sclk);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL reset_done: got %b want 0", done);
    end
    total++;
    if (ovr !== 1'b0) begin
      bad++; $display("FAIL reset_ovr: got %b want 0", ovr);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [2*FB-1:0] v;
    logic [2*FB-1:0] exp_v;
    int n, sz;
    clear_mon();
    data = 8'hA5;
    en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (txd !== 1'b1) begin
      bad++; $display("FAIL single_lat_e0: txd=%b want 1", txd);
    end
    @(negedge clk);
    total++;
    if (txd !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_lat_e1: txd=%b busy=%b want 1 1", txd, busy);
    end
    @(negedge clk);
    en = 1'b0;
    total++;
    if (txd !== 1'b0) begin
      bad++; $display("FAIL single_lat_e2: txd=%b want 0", txd);
    end
    total++;
    if (sclk !== 1'b0) begin
      bad++; $display("FAIL single_sclk_lo: sclk=%b want 0", sclk);
    end
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        total++;
        if (sclk !== 1'b1) begin
          bad++; $display("FAIL single_sclk_hi: sclk=%b want 1", sclk);
        end
      end
    end
    total++;
    if (n != FCLK) begin
      bad++; $display("FAIL single_len: clocks=%0d want %0d", n, FCLK);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL single_busy_drop: busy=%b want 0", busy);
    end
    repeat (4) @(posedge clk);
    #1;
    pack_rx(v, sz);
    exp_v = {{FB{1'b0}}, frame_of(8'hA5)};
    total++;
    if (sz != FB || v !== exp_v) begin
      bad++;
      $display("FAIL single_bits: n=%0d bits=%b want n=%0d bits=%b",
               sz, v, FB, exp_v);
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL single_done: pulses=%0d want 1", done_cnt);
    end
  endtask

  task automatic test_long_enable();
    logic [2*FB-1:0] v;
    logic [2*FB-1:0] exp_v;
    int sz;
    clear_mon();
    bus_write(8'h3C, 5);
    wait_idle("long_en");
    pack_rx(v, sz);
    exp_v = {{FB{1'b0}}, frame_of(8'h3C)};
    total++;
    if (sz != FB || v !== exp_v) begin
      bad++;
      $display("FAIL long_en_bits: n=%0d bits=%b want n=%0d bits=%b",
               sz, v, FB, exp_v);
    end
    total++;
    if (done_cnt != 1 || ovr_cnt != 0) begin
      bad++;
      $display("FAIL long_en_pulses: done=%0d ovr=%0d want 1 0",
               done_cnt, ovr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*FB-1:0] v;
    logic [2*FB-1:0] exp_v;
    int sz, n, seen, gap, d1, d2;
    bit after;
    clear_mon();
    bus_write(8'h11, 2);
    repeat (10) @(posedge clk);
    #1;
    bus_write(8'h22, 2);
    n = 0; seen = 0; gap = 0; d1 = 0; d2 = 0; after = 1'b0;
    while (seen < 2 && n < 400) begin
      @(negedge clk);
      n++;
      if (!busy) gap++;
      if (after) begin
        after = 1'b0;
        total++;
        if (txd !== 1'b0) begin
          bad++; $display("FAIL b2b_start: txd=%b want 0", txd);
        end
      end
      if (done) begin
        seen++;
        if (seen == 1) begin
          d1 = n; after = 1'b1;
        end else begin
          d2 = n;
        end
      end
    end
    total++;
    if (seen != 2 || d2 - d1 != FCLK) begin
      bad++;
      $display("FAIL b2b_spacing: dones=%0d gap=%0d want 2 %0d",
               seen, d2 - d1, FCLK);
    end
    total++;
    if (gap != 0) begin
      bad++; $display("FAIL b2b_busy: low_cycles=%0d want 0", gap);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_busy_drop: busy=%b want 0", busy);
    end
    repeat (3) @(posedge clk);
    #1;
    pack_rx(v, sz);
    exp_v = {frame_of(8'h22), frame_of(8'h11)};
    total++;
    if (sz != 2*FB || v !== exp_v) begin
      bad++;
      $display("FAIL b2b_bits: n=%0d bits=%b want n=%0d bits=%b",
               sz, v, 2*FB, exp_v);
    end
    total++;
    if (ovr_cnt != 0) begin
      bad++; $display("FAIL b2b_ovr: pulses=%0d want 0", ovr_cnt);
    end
  endtask

  task automatic test_overrun();
    logic [2*FB-1:0] v;
    logic [2*FB-1:0] exp_v;
    int sz;
    clear_mon();
    bus_write(8'h11, 2);
    repeat (5) @(posedge clk);
    #1;
    bus_write(8'h22, 2);
    repeat (5) @(posedge clk);
    #1;
    data = 8'h33;
    en   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ovr !== 1'b1) begin
      bad++; $display("FAIL ovr_pulse: ovr=%b want 1", ovr);
    end
    en = 1'b0;
    @(negedge clk);
    total++;
    if (ovr !== 1'b0) begin
      bad++; $display("FAIL ovr_width: ovr=%b want 0", ovr);
    end
    wait_idle("overrun");
    pack_rx(v, sz);
    exp_v = {frame_of(8'h22), frame_of(8'h11)};
    total++;
    if (sz != 2*FB || v !== exp_v) begin
      bad++;
      $display("FAIL ovr_bits: n=%0d bits=%b want n=%0d bits=%b",
               sz, v, 2*FB, exp_v);
    end
    total++;
    if (ovr_cnt != 1 || done_cnt != 2) begin
      bad++;
      $display("FAIL ovr_counts: ovr=%0d done=%0d want 1 2",
               ovr_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*FB-1:0] v;
    logic [2*FB-1:0] exp_v;
    int sz, n;
    clear_mon();
    bus_write(8'hC3, 2);
    n = 0;
    while (txd && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Frame cycle 1 is here; data bit 3 occupies cycles 17..20.
    repeat (17) @(negedge clk);
    total++;
    if (txd !== 1'b0 || sclk !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre: txd=%b sclk=%b want 0 0", txd, sclk);
    end
    done_cnt = 0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({txd, sclk, busy, done, ovr} !== 5'b11000) begin
      bad++;
      $display("FAIL mid_reset_outs: got %b want 11000",
               {txd, sclk, busy, done, ovr});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    total++;
    if (done_cnt != 0 || busy !== 1'b0 || txd !== 1'b1) begin
      bad++;
      $display("FAIL mid_no_done: done=%0d busy=%b txd=%b want 0 0 1",
               done_cnt, busy, txd);
    end
    clear_mon();
    bus_write(8'h5A, 2);
    wait_idle("after_reset");
    pack_rx(v, sz);
    exp_v = {{FB{1'b0}}, frame_of(8'h5A)};
    total++;
    if (sz != FB || v !== exp_v) begin
      bad++;
      $display("FAIL mid_after_bits: n=%0d bits=%b want n=%0d bits=%b",
               sz, v, FB, exp_v);
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL mid_after_done: pulses=%0d want 1", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_long_enable();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
